// File: rtl/uart_mmio_if.sv
// CPU memory-bus slave port for uart_mmio: chip select, byte strobes,
// word address, write/read data and the single-cycle ready acknowledge.
interface uart_mmio_if;
  logic        cs;
  logic [3:0]  we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output cs, we, addr, wdata, input rdata, ready);
  modport slave  (input cs, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serializer on txd, a one-byte
// buffered receiver on rxd, and DATA/STATUS/DIV registers on a bus whose
// ready is acknowledged one cycle after chip select.
module uart_mmio #(
  parameter int CLK_HZ   = 25_000_000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_mmio_if.slave bus,
  input  logic       rxd,
  output logic       txd
);

  localparam int          AW        = $clog2(TX_DEPTH);
  localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);
  localparam logic [15:0] DIV_MIN   = 16'd4;
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // Bus side
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        rd_valid_q;
  logic [31:0] rd_mux;
  logic        bus_rd, bus_wr;
  logic        push, data_pop, div_wr, st_wr;
  logic [15:0] divisor;

  // TX FIFO
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        tx_full, tx_empty;
  logic [7:0]  fifo_head;

  // TX serializer
  uart_state_t tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic [7:0]  tx_shift, tx_shift_d;
  logic        txd_q, txd_d;
  logic        tx_pop, tx_bit_end, tx_busy;

  // RX deserializer
  logic [1:0]  rx_sync;
  logic        rx_s, rx_prev;
  uart_state_t rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic [7:0]  rx_shift, rx_shift_d;
  logic        rx_done, rx_stop_ok;
  logic        rx_valid, overrun, frame_err;
  logic [7:0]  rx_byte;

  logic unused_bits;
  assign unused_bits = ^bus.wdata[31:16];

  // Side effects happen only in the ready cycle, so each transaction acts once.
  assign bus_rd   = ready_q && bus.cs && (bus.we == 4'b0000);
  assign bus_wr   = ready_q && bus.cs && (bus.we != 4'b0000);
  assign push     = bus_wr && (bus.addr == 2'd0) && bus.we[0] && !tx_full;
  assign data_pop = bus_rd && (bus.addr == 2'd0) && rd_valid_q;
  assign div_wr   = bus_wr && (bus.addr == 2'd2) && (bus.we[1:0] == 2'b11);
  assign st_wr    = bus_wr && (bus.addr == 2'd1) && bus.we[0];

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign txd       = txd_q;
  assign tx_busy   = (tx_state != ST_IDLE);

  // Register read multiplexer.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    rd_mux = '0;
    case (bus.addr)
      2'd0:    if (rx_valid) rd_mux = {1'b1, 23'b0, rx_byte};
      2'd1:    rd_mux = {26'b0, frame_err, tx_busy, overrun, rx_valid, tx_empty, tx_full};
      2'd2:    rd_mux = {16'b0, divisor};
      default: rd_mux = '0;
    endcase
  end

  // Bus acknowledge and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or block order.
    if (!rst_n) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      ready_q    <= bus.cs && !ready_q;
      rdata_q    <= (bus.cs && !ready_q && bus.we == 4'b0000) ? rd_mux : '0;
      // Remember whether the DATA read actually returned a byte; only then may it consume it.
      rd_valid_q <= bus.cs && !ready_q && (bus.we == 4'b0000) && (bus.addr == 2'd0) && rx_valid;
    end
  end

  // Baud divisor register, clamped to the shortest workable bit time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) divisor <= DIV_RESET;
    else if (div_wr) divisor <= (bus.wdata[15:0] < DIV_MIN) ? DIV_MIN : bus.wdata[15:0];
  end

  // TX FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; the pointers alone decide
    // which entries are valid, and a reset-less array can map onto RAM.
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.wdata[7:0];
  end

  // TX FIFO pointers; an extra wrap bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (tx_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign tx_empty  = (wr_ptr == rd_ptr);
  assign tx_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head = fifo_mem[rd_ptr[AW-1:0]];

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);

  // TX next-state: one bit time per state, chaining frames with no idle gap.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 16'd1;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_div_d   = tx_div;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_head;
          tx_div_d   = divisor;
          txd_d      = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        txd_d      = tx_shift[0];
        tx_state_d = ST_DATA;
      end
      ST_DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        if (tx_bit == 3'd7) begin
          txd_d      = 1'b1;
          tx_state_d = ST_STOP;
        end else begin
          tx_shift_d = tx_shift >> 1;
          txd_d      = tx_shift[1];
          tx_bit_d   = tx_bit + 3'd1;
        end
      end
      ST_STOP: if (tx_bit_end) begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_head;
          tx_div_d   = divisor;
          txd_d      = 1'b0;
          tx_state_d = ST_START;
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // TX state register; txd is registered so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_div   <= DIV_RESET;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      tx_div   <= tx_div_d;
      txd_q    <= txd_d;
    end
  end

  // Two-flop synchronizer for the asynchronous serial input, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = rx_sync[1];

  // RX next-state: sample mid-bit, rejecting starts that do not last half a bit.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 16'd1;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_div_d   = rx_div;
    rx_done    = 1'b0;
    rx_stop_ok = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_s) begin
          rx_div_d   = divisor;
          rx_state_d = ST_START;
        end
      end
      ST_START: if (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_cnt == rx_div - 16'd1) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_d = ST_STOP;
        else                rx_bit_d   = rx_bit + 3'd1;
      end
      ST_STOP: if (rx_cnt == rx_div - 16'd1) begin
        rx_cnt_d   = '0;
        rx_done    = 1'b1;
        rx_stop_ok = rx_s;
        rx_state_d = ST_IDLE;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_div   <= DIV_RESET;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
      rx_div   <= rx_div_d;
    end
  end

  // Receive buffer and sticky error flags; a completing byte beats a concurrent read-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_done && rx_stop_ok && (!rx_valid || data_pop)) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (data_pop) begin
        rx_valid <= 1'b0;
      end

      if (rx_done && rx_stop_ok && rx_valid && !data_pop) overrun <= 1'b1;
      else if (st_wr && bus.wdata[3])                     overrun <= 1'b0;

      if (rx_done && !rx_stop_ok)           frame_err <= 1'b1;
      else if (st_wr && bus.wdata[5])       frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register reset values, TX framing and
// latency, FIFO fill/drop with back-to-back frames, RX buffering, overrun,
// false starts, framing errors and asynchronous reset mid-frame.
module tb_uart_mmio;
  localparam int DIV0 = 217;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic txd;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;

  uart_mmio_if bus ();

  uart_mmio #(.CLK_HZ(25_000_000), .BAUD(115200), .TX_DEPTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .rxd  (rxd),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level for bit slot i of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic bus_xfer(input logic [1:0] a, input logic [3:0] w,
                          input logic [31:0] d, output logic [31:0] q);
    int n;
    @(negedge clk);
    bus.cs = 1'b1; bus.addr = a; bus.we = w; bus.wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ready !== 1'b1 && n < 8);
    q = bus.rdata;
    if (bus.ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL bus_timeout: ready=%b after %0d cycles, required 1", bus.ready, n);
    end
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 4'b0000;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] q);
    bus_xfer(a, 4'b0000, 32'h0, q);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(a, w, d, dummy);
  endtask

  // Waits for a start bit on txd and samples the frame at mid-bit.
  task automatic tx_capture(input int div, output logic [7:0] b, output logic stop_bit,
                            output int start_cyc, output bit to);
    int n;
    b = '0; stop_bit = 1'b0; start_cyc = 0; to = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while (txd !== 1'b0 && n < 5000);
    if (txd !== 1'b0) begin to = 1'b1; return; end
    start_cyc = cyc;
    repeat (div / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (div) @(negedge clk);
      b[k] = txd;
    end
    repeat (div) @(negedge clk);
    stop_bit = txd;
  endtask

  task automatic uart_send(input logic [7:0] b, input int div, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (div) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (div) @(negedge clk);
    end
    rxd = stop;
    repeat (div) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] q;
    bus.cs = 1'b0; bus.we = 4'b0000; bus.addr = 2'd0; bus.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Hand-driven STATUS read to pin down the one-cycle ready latency.
    bus.cs = 1'b1; bus.addr = 2'd1; bus.we = 4'b0000;
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL ready_latency: got %b expected 1", bus.ready); end
    checks++; if (bus.rdata !== 32'h2) begin errors++; $display("FAIL status_reset: got %h expected 00000002", bus.rdata); end
    @(posedge clk); #1; bus.cs = 1'b0;
    @(negedge clk);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: got %b expected 0", bus.ready); end
    bus_read(2'd2, q);
    checks++; if (q !== 32'd217) begin errors++; $display("FAIL div_reset: got %h expected %h", q, 32'd217); end
    bus_read(2'd0, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL data_reset: got %h expected 00000000", q); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL idle_txd: got %b expected 1", txd); end
  endtask

  task automatic test_tx_frame;
    logic [31:0] q, qs;
    int bad, first_bad;
    bus_write(2'd0, 4'b0001, 32'h55);
    bad = 0; first_bad = -1;
    fork
      begin
        @(negedge clk);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL tx_not_early: got %b expected 1", txd); end
        for (int c = 0; c < 10 * DIV0; c++) begin
          @(negedge clk);
          if (txd !== frame_bit(8'h55, c / DIV0)) begin
            bad++;
            if (first_bad < 0) first_bad = c;
          end
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL tx_frame_55: %0d wrong cycles (first at %0d), required 0", bad, first_bad);
        end
      end
      begin
        repeat (600) @(negedge clk);
        bus_read(2'd1, qs);
        checks++; if (qs !== 32'h12) begin errors++; $display("FAIL tx_busy_status: got %h expected 00000012", qs); end
      end
    join
    repeat (5) @(negedge clk);
    bus_read(2'd1, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL tx_done_status: got %h expected 00000002", q); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b expected 1", txd); end
  endtask

  task automatic test_fifo_full;
    logic [7:0]  b;
    logic        sb;
    int          st, prev, lows;
    bit          to;
    logic [31:0] q, qb;
    bus_write(2'd0, 4'b0001, 32'hA5);
    fork
      begin
        tx_capture(DIV0, b, sb, prev, to);
        checks++;
        if (to || b !== 8'hA5 || sb !== 1'b1) begin
          errors++; $display("FAIL fifo_filler: got byte %h stop %b timeout %0d expected A5 1 0", b, sb, to);
        end
        for (int i = 0; i < 16; i++) begin
          tx_capture(4, b, sb, st, to);
          checks++;
          if (to || b !== 8'(i)) begin
            errors++; $display("FAIL fifo_byte_%0d: got %h timeout %0d expected %h", i, b, to, 8'(i));
          end
          checks++;
          if (st - prev != ((i == 0) ? 10 * DIV0 : 40)) begin
            errors++; $display("FAIL fifo_gap_%0d: got %0d cycles expected %0d", i, st - prev, (i == 0) ? 10 * DIV0 : 40);
          end
          prev = st;
        end
        lows = 0;
        repeat (300) begin @(negedge clk); if (txd !== 1'b1) lows++; end
        checks++; if (lows != 0) begin errors++; $display("FAIL fifo_no_extra: got %0d low cycles expected 0", lows); end
      end
      begin
        bus_write(2'd2, 4'b0011, 32'h1);
        bus_read(2'd2, qb);
        checks++; if (qb !== 32'h4) begin errors++; $display("FAIL div_clamp: got %h expected 00000004", qb); end
        bus_write(2'd2, 4'b0001, 32'h9);
        bus_read(2'd2, qb);
        checks++; if (qb !== 32'h4) begin errors++; $display("FAIL div_partial_we: got %h expected 00000004", qb); end
        for (int i = 0; i < 17; i++) begin
          bus_write(2'd0, 4'b0001, 32'(i));
          if (i == 15) begin
            bus_read(2'd1, qb);
            checks++; if (qb !== 32'h11) begin errors++; $display("FAIL full_at_16: got %h expected 00000011", qb); end
          end
        end
        bus_read(2'd1, qb);
        checks++; if (qb !== 32'h11) begin errors++; $display("FAIL full_after_17: got %h expected 00000011", qb); end
      end
    join
    bus_read(2'd1, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL fifo_drained: got %h expected 00000002", q); end
  endtask

  task automatic test_rx;
    logic [31:0] q;
    bus_write(2'd2, 4'b0011, 32'd217);
    uart_send(8'hA3, DIV0, 1'b1);
    bus_read(2'd1, q);
    checks++; if (q !== 32'h6) begin errors++; $display("FAIL rx_valid_status: got %h expected 00000006", q); end
    bus_read(2'd0, q);
    checks++; if (q !== 32'h800000A3) begin errors++; $display("FAIL rx_data_a3: got %h expected 800000A3", q); end
    bus_read(2'd0, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rx_data_empty: got %h expected 00000000", q); end
    uart_send(8'h3C, DIV0, 1'b1);
    uart_send(8'h5A, DIV0, 1'b1);
    bus_read(2'd1, q);
    checks++; if (q !== 32'hE) begin errors++; $display("FAIL rx_overrun: got %h expected 0000000E", q); end
    bus_write(2'd1, 4'b0001, 32'h8);
    bus_read(2'd1, q);
    checks++; if (q !== 32'h6) begin errors++; $display("FAIL overrun_clear: got %h expected 00000006", q); end
    bus_read(2'd0, q);
    checks++; if (q !== 32'h8000003C) begin errors++; $display("FAIL rx_first_kept: got %h expected 8000003C", q); end
  endtask

  task automatic test_rx_errors;
    logic [31:0] q;
    @(negedge clk); rxd = 1'b0;
    repeat (50) @(negedge clk);
    rxd = 1'b1;
    repeat (400) @(negedge clk);
    bus_read(2'd1, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL rx_glitch: got %h expected 00000002", q); end
    uart_send(8'h81, DIV0, 1'b0);
    bus_read(2'd1, q);
    checks++; if (q !== 32'h22) begin errors++; $display("FAIL frame_err: got %h expected 00000022", q); end
    bus_write(2'd1, 4'b0001, 32'h20);
    bus_read(2'd1, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL frame_err_clear: got %h expected 00000002", q); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] q;
    int n, lows;
    for (int i = 0; i < 3; i++) bus_write(2'd0, 4'b0001, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (txd !== 1'b0 && n < 20);
    repeat (50) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL mid_frame_low: got %b expected 0", txd); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL async_reset_txd: got %b expected 1", txd); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_read(2'd1, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL post_reset_status: got %h expected 00000002", q); end
    bus_read(2'd2, q);
    checks++; if (q !== 32'd217) begin errors++; $display("FAIL post_reset_div: got %h expected %h", q, 32'd217); end
    lows = 0;
    repeat (2500) begin @(negedge clk); if (txd !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL no_residual_frame: got %0d low cycles expected 0", lows); end
  endtask

  initial begin
    test_reset;
    test_tx_frame;
    test_fifo_full;
    test_rx;
    test_rx_errors;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
